// File: rtl/iomem_arbiter.sv
// iomem_arbiter: round-robin sharing of one PicoSoC iomem slave bus between two masters.
// Optional slave-ready timeout is built only when IOMEM_ARB_TIMEOUT_EN is defined.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             last_grant_reg, last_grant_next;
    logic [1:0]       ready_reg, ready_next;
    logic [1:0][31:0] rdata_reg, rdata_next;
    logic [1:0]       m_valid;
    logic [1:0]       eligible;
    logic [1:0]       grant_onehot;
    logic             active;
    logic             finish;
    logic             timeout_hit;

    assign m_valid      = {m1_valid, m0_valid};
    assign grant_onehot = {state_reg == GNT1, state_reg == GNT0};
    assign active       = |grant_onehot;
    assign finish       = active && (s_ready || timeout_hit);

    // A master whose ready is high is still holding valid for the completed
    // access, so it must not be treated as a fresh request in that cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign eligible[gi]   = m_valid[gi] && !ready_reg[gi];
        assign ready_next[gi] = finish && grant_onehot[gi];
        assign rdata_next[gi] = ready_next[gi] ? (timeout_hit ? TIMEOUT_RDATA : s_rdata)
                                               : rdata_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            ready_reg      <= '0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            ready_reg      <= ready_next;
            rdata_reg      <= rdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        unique case (state_reg)
            IDLE: begin
                if (eligible[0] && (!eligible[1] || last_grant_reg)) begin
                    state_next      = GNT0;
                    last_grant_next = 1'b0;
                end else if (eligible[1]) begin
                    state_next      = GNT1;
                    last_grant_next = 1'b1;
                end
            end
            GNT0, GNT1: begin
                if (s_ready || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slave bus is driven from the granted master only; zero when idle.
    always_comb begin
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (grant_onehot[0]) begin
            s_wstrb = m0_wstrb;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
        end else if (grant_onehot[1]) begin
            s_wstrb = m1_wstrb;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end
    end

    assign s_valid  = active;
    assign m0_ready = ready_reg[0];
    assign m1_ready = ready_reg[1];
    assign m0_rdata = rdata_reg[0];
    assign m1_rdata = rdata_reg[1];

`ifdef IOMEM_ARB_TIMEOUT_EN
    logic [7:0] count_reg;
    logic       timeout_pulse_reg;

    // A slave ready arriving in the limit cycle still completes normally.
    assign timeout_hit = active && !s_ready && (count_reg == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_reg         <= '0;
            timeout_pulse_reg <= 1'b0;
        end else begin
            timeout_pulse_reg <= timeout_hit;
            if (!active) begin
                count_reg <= '0;
            end else if (!s_ready && !timeout_hit) begin
                count_reg <= count_reg + 8'd1;
            end
        end
    end

    assign timeout_pulse = timeout_pulse_reg;
`else
    logic [7:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
    assign timeout_hit           = 1'b0;
    assign timeout_pulse         = 1'b0;
`endif

endmodule
